unified_mem_arbiter: RTL

Shares one single-ported unified instruction/data memory between the fetch path (PC) and the load/store path of the RISC-V core. Grants one requester at a time and drives a ready-handshake memory port. Returns read data with a one-cycle valid pulse. Supports halt on ebreak (pcload low), fetch flush on a taken branch or jump, and a bus timeout.

---
 rtl/arb_defs.sv | 14 +
 rtl/arb_perf_cnt.sv | 27 ++
 rtl/unified_mem_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/arb_defs.sv
// Shared definitions for the unified memory arbiter: FSM state encoding
// and transaction owner codes.
package arb_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

endpackage

// File: rtl/arb_perf_cnt.sv
// Performance counters for the unified memory arbiter: fetch grants, data
// grants and requester stall cycles. All counters wrap modulo 2^32.
module arb_perf_cnt (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_grant,
  input  logic        d_grant,
  input  logic        stall,
  output logic [31:0] perf_if_grants,
  output logic [31:0] perf_d_grants,
  output logic [31:0] perf_stall_cyc
);

  // Count grants and stall cycles; wrap naturally on overflow.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_if_grants <= 32'd0;
      perf_d_grants  <= 32'd0;
      perf_stall_cyc <= 32'd0;
    end else begin
      perf_if_grants <= if_grant ? perf_if_grants + 32'd1 : perf_if_grants;
      perf_d_grants  <= d_grant  ? perf_d_grants  + 32'd1 : perf_d_grants;
      perf_stall_cyc <= stall    ? perf_stall_cyc + 32'd1 : perf_stall_cyc;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Unified instruction/data memory arbiter. One single-ported memory is shared
// between fetch and load/store; one transaction runs at a time through
// IDLE -> BUSY -> RESP. Data normally wins, but after MAX_DATA_RUN data grants
// with fetch waiting, fetch is served. A BUSY access that sees no mem_ready for
// TIMEOUT_CYC cycles is abandoned and reported with bus_err.
// Optional macro ARB_PERF_CNT_EN adds grant and stall performance counters.
module unified_mem_arbiter
  import arb_defs::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int MAX_DATA_RUN = 4,
  parameter int TIMEOUT_CYC  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_valid,
  output logic [DATA_W-1:0] d_rdata,
  input  logic              halt,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              bus_err
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0]       perf_if_grants,
  output logic [31:0]       perf_d_grants,
  output logic [31:0]       perf_stall_cyc
`endif
);

  localparam int RUN_W = $clog2(MAX_DATA_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_DATA_RUN);
  localparam logic [7:0]       TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_t           state_r;
  logic             owner_r;
  logic             cancel_r;
  logic [7:0]       tmo_cnt_r;
  logic [RUN_W-1:0] data_run_r;
  logic             grant_if_s;
  logic             grant_d_s;
  logic             run_full_s;
  logic             kill_if_s;

  // Grant decision in IDLE: fetch wins only when eligible and data has had its run.
  always_comb begin
    grant_if_s = 1'b0;
    grant_d_s  = 1'b0;
    run_full_s = (data_run_r == RUN_MAX);
    if (state_r == ST_IDLE) begin
      if (if_req && !halt && (!d_req || run_full_s)) begin
        grant_if_s = 1'b1;
      end else if (d_req) begin
        grant_d_s = 1'b1;
      end else begin
        grant_if_s = 1'b0;
        grant_d_s  = 1'b0;
      end
    end else begin
      grant_if_s = 1'b0;
      grant_d_s  = 1'b0;
    end
  end

  // A fetch response is dropped if flushed earlier or in the completing cycle.
  always_comb begin
    kill_if_s = cancel_r | flush;
  end

  // Consecutive data grants while fetch waits; saturates at MAX_DATA_RUN.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_run_r <= {RUN_W{1'b0}};
    end else if (state_r == ST_IDLE) begin
      if (grant_if_s || !if_req) begin
        data_run_r <= {RUN_W{1'b0}};
      end else if (grant_d_s && !run_full_s) begin
        data_run_r <= data_run_r + RUN_W'(1);
      end else begin
        data_run_r <= data_run_r;
      end
    end else begin
      data_run_r <= data_run_r;
    end
  end

  // Arbiter FSM with registered memory port, response and error outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r   <= ST_IDLE;
      owner_r   <= OWN_IF;
      cancel_r  <= 1'b0;
      tmo_cnt_r <= 8'd0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= {ADDR_W{1'b0}};
      mem_wdata <= {DATA_W{1'b0}};
      if_valid  <= 1'b0;
      if_rdata  <= {DATA_W{1'b0}};
      d_valid   <= 1'b0;
      d_rdata   <= {DATA_W{1'b0}};
      bus_err   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if_valid  <= 1'b0;
          d_valid   <= 1'b0;
          bus_err   <= 1'b0;
          cancel_r  <= 1'b0;
          tmo_cnt_r <= 8'd0;
          if (grant_if_s) begin
            owner_r   <= OWN_IF;
            mem_req   <= 1'b1;
            mem_we    <= 1'b0;
            mem_addr  <= if_addr;
            mem_wdata <= {DATA_W{1'b0}};
            state_r   <= ST_BUSY;
          end else if (grant_d_s) begin
            owner_r   <= OWN_D;
            mem_req   <= 1'b1;
            mem_we    <= d_we;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            state_r   <= ST_BUSY;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_BUSY: begin
          if (flush && owner_r == OWN_IF) cancel_r <= 1'b1;
          if (mem_ready) begin
            mem_req   <= 1'b0;
            tmo_cnt_r <= 8'd0;
            state_r   <= ST_RESP;
            if (owner_r == OWN_IF) begin
              if_rdata <= mem_rdata;
              if_valid <= ~kill_if_s;
            end else begin
              d_rdata <= mem_we ? {DATA_W{1'b0}} : mem_rdata;
              d_valid <= 1'b1;
            end
          end else if (tmo_cnt_r == TMO_LAST) begin
            mem_req   <= 1'b0;
            tmo_cnt_r <= 8'd0;
            bus_err   <= 1'b1;
            state_r   <= ST_RESP;
            if (owner_r == OWN_IF) begin
              if_rdata <= {DATA_W{1'b0}};
              if_valid <= ~kill_if_s;
            end else begin
              d_rdata <= {DATA_W{1'b0}};
              d_valid <= 1'b1;
            end
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 8'd1;
          end
        end
        ST_RESP: begin
          // A flush landing here cannot retract the already registered pulse.
          if (flush && owner_r == OWN_IF) cancel_r <= 1'b1;
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          bus_err  <= 1'b0;
          state_r  <= ST_IDLE;
        end
        default: begin
          mem_req  <= 1'b0;
          if_valid <= 1'b0;
          d_valid  <= 1'b0;
          bus_err  <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef ARB_PERF_CNT_EN
  logic stall_s;

  // A requester is stalled every cycle it asks and is not being answered.
  always_comb begin
    stall_s = (if_req & ~if_valid) | (d_req & ~d_valid);
  end

  arb_perf_cnt u_perf (
    .clk            (clk),
    .rst            (rst),
    .if_grant       (grant_if_s),
    .d_grant        (grant_d_s),
    .stall          (stall_s),
    .perf_if_grants (perf_if_grants),
    .perf_d_grants  (perf_d_grants),
    .perf_stall_cyc (perf_stall_cyc)
  );
`endif

endmodule
